// File: rtl/trigger_seq_pkg.sv
// Shared definitions for the trigger sequencer: state encoding, register map
// defaults, control/status bit positions and a byte-lane read helper.
package trigger_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_FIRE    = 3'd2,
    S_HOLDOFF = 3'd3,
    S_DONE    = 3'd4,
    S_TOUT    = 3'd5
  } seq_state_e;

  localparam logic [7:0] ADDR_CTRL_DEF    = 8'h30;
  localparam logic [7:0] ADDR_SKIP_DEF    = 8'h31;
  localparam logic [7:0] ADDR_REPEAT_DEF  = 8'h32;
  localparam logic [7:0] ADDR_HOLDOFF_DEF = 8'h33;
  localparam logic [7:0] ADDR_TIMEOUT_DEF = 8'h34;
  localparam logic [7:0] ADDR_STATUS_DEF  = 8'h35;

  localparam int CTRL_ARM_BIT   = 0;
  localparam int CTRL_ABORT_BIT = 1;

  localparam int STAT_DONE_BIT    = 3;
  localparam int STAT_TIMEOUT_BIT = 4;
  localparam int STAT_OVERRUN_BIT = 5;

  localparam logic [15:0] REPEAT_RST = 16'd1;

  // Little-endian byte select; lanes past the padded value read as zero.
  function automatic logic [7:0] sel_byte(input logic [31:0] val, input logic [15:0] idx);
    sel_byte = 8'h00;
    for (int b = 0; b < 4; b++) begin
      if (idx == 16'(b)) sel_byte = val[b*8 +: 8];
    end
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter that holds at zero instead of wrapping.
module seq_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/trigger_sequencer.sv
// Register-bus controlled trigger sequencer: skip-gated edges, repeated fires
// separated by a holdoff window, optional arm timeout.
module trigger_sequencer
  import trigger_seq_pkg::*;
#(
  parameter logic [7:0] ADDR_CTRL    = ADDR_CTRL_DEF,
  parameter logic [7:0] ADDR_SKIP    = ADDR_SKIP_DEF,
  parameter logic [7:0] ADDR_REPEAT  = ADDR_REPEAT_DEF,
  parameter logic [7:0] ADDR_HOLDOFF = ADDR_HOLDOFF_DEF,
  parameter logic [7:0] ADDR_TIMEOUT = ADDR_TIMEOUT_DEF,
  parameter logic [7:0] ADDR_STATUS  = ADDR_STATUS_DEF
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic [7:0]  reg_cmd,
  input  logic [15:0] reg_bytecount,
  input  logic [7:0]  reg_data_in,
  input  logic        reg_read,
  input  logic        reg_write,
  output logic [7:0]  data_read,
  input  logic        trigger_in,
  output logic        trigger_out,
  output logic        armed,
  output logic [5:0]  status_led
);

  seq_state_e  r_state, w_state_nxt;
  logic [15:0] r_skip, r_repeat, r_fire_count;
  logic [31:0] r_holdoff, r_timeout;
  logic        r_done, r_timeout_flag, r_overrun, r_trig_q;
  logic [7:0]  r_data_read;

  logic        w_cfg_open, w_wr_ctrl, w_abort, w_arm, w_edge;
  logic        w_skip_load, w_skip_en, w_skip_zero;
  logic        w_rep_load, w_rep_en, w_rep_zero, w_rep_last;
  logic        w_hold_load, w_hold_en, w_hold_zero, w_hold_last;
  logic        w_tmo_load, w_tmo_en, w_tmo_zero, w_tmo_last;
  logic [15:0] w_skip_cnt, w_rep_cnt, w_rep_load_val;
  logic [31:0] w_hold_cnt, w_tmo_cnt;
  logic        w_fire, w_set_done, w_set_tout, w_set_ovr;
  logic [7:0]  w_status0;
  logic        w_unused_skip;

  assign w_cfg_open = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_TOUT);
  assign w_wr_ctrl  = reg_write && (reg_cmd == ADDR_CTRL) && (reg_bytecount == 16'd0);
  assign w_abort    = w_wr_ctrl && reg_data_in[CTRL_ABORT_BIT];
  assign w_arm      = w_wr_ctrl && reg_data_in[CTRL_ARM_BIT] && !w_abort && w_cfg_open;
  assign w_edge     = trigger_in && !r_trig_q;

  assign w_rep_load_val = (r_repeat == 16'd0) ? 16'd1 : r_repeat;
  assign w_rep_last     = w_rep_zero  || (w_rep_cnt  == 16'd1);
  assign w_hold_last    = w_hold_zero || (w_hold_cnt == 32'd1);
  assign w_tmo_last     = w_tmo_zero  || (w_tmo_cnt  == 32'd1);
  assign w_unused_skip  = ^w_skip_cnt;

  seq_down_counter #(.WIDTH(16)) u_skip_cnt (
    .i_clk(clkin), .i_rst(reset), .i_load(w_skip_load), .i_load_val(r_skip),
    .i_en(w_skip_en), .o_count(w_skip_cnt), .o_zero(w_skip_zero)
  );

  seq_down_counter #(.WIDTH(16)) u_rep_cnt (
    .i_clk(clkin), .i_rst(reset), .i_load(w_rep_load), .i_load_val(w_rep_load_val),
    .i_en(w_rep_en), .o_count(w_rep_cnt), .o_zero(w_rep_zero)
  );

  seq_down_counter #(.WIDTH(32)) u_hold_cnt (
    .i_clk(clkin), .i_rst(reset), .i_load(w_hold_load), .i_load_val(r_holdoff),
    .i_en(w_hold_en), .o_count(w_hold_cnt), .o_zero(w_hold_zero)
  );

  seq_down_counter #(.WIDTH(32)) u_tmo_cnt (
    .i_clk(clkin), .i_rst(reset), .i_load(w_tmo_load), .i_load_val(r_timeout),
    .i_en(w_tmo_en), .o_count(w_tmo_cnt), .o_zero(w_tmo_zero)
  );

  // Configuration is frozen while a sequence is in flight.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_skip    <= '0;
      r_repeat  <= REPEAT_RST;
      r_holdoff <= '0;
      r_timeout <= '0;
    end else if (reg_write && w_cfg_open) begin
      for (int b = 0; b < 2; b++) begin
        if (reg_bytecount == 16'(b)) begin
          if (reg_cmd == ADDR_SKIP)   r_skip[b*8 +: 8]   <= reg_data_in;
          if (reg_cmd == ADDR_REPEAT) r_repeat[b*8 +: 8] <= reg_data_in;
        end
      end
      for (int b = 0; b < 4; b++) begin
        if (reg_bytecount == 16'(b)) begin
          if (reg_cmd == ADDR_HOLDOFF) r_holdoff[b*8 +: 8] <= reg_data_in;
          if (reg_cmd == ADDR_TIMEOUT) r_timeout[b*8 +: 8] <= reg_data_in;
        end
      end
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_trig_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_trig_q <= trigger_in;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_skip_load = 1'b0;
    w_skip_en   = 1'b0;
    w_rep_load  = 1'b0;
    w_rep_en    = 1'b0;
    w_hold_load = 1'b0;
    w_hold_en   = 1'b0;
    w_tmo_load  = 1'b0;
    w_tmo_en    = 1'b0;
    w_fire      = 1'b0;
    w_set_done  = 1'b0;
    w_set_tout  = 1'b0;
    w_set_ovr   = 1'b0;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_TOUT: begin
          if (w_arm) begin
            w_state_nxt = S_ARMED;
            w_skip_load = 1'b1;
            w_rep_load  = 1'b1;
            w_tmo_load  = 1'b1;
          end
        end
        S_ARMED: begin
          w_tmo_en = (r_timeout != 32'd0);
          // An edge landing on the expiry cycle still wins over the timeout.
          if (w_edge) begin
            if (w_skip_zero) w_state_nxt = S_FIRE;
            else             w_skip_en   = 1'b1;
          end else if (w_tmo_en && w_tmo_last) begin
            w_state_nxt = S_TOUT;
            w_set_tout  = 1'b1;
          end
        end
        S_FIRE: begin
          w_fire   = 1'b1;
          w_rep_en = 1'b1;
          if (w_rep_last) begin
            w_state_nxt = S_DONE;
            w_set_done  = 1'b1;
          end else if (r_holdoff != 32'd0) begin
            w_state_nxt = S_HOLDOFF;
            w_hold_load = 1'b1;
          end else begin
            w_state_nxt = S_ARMED;
          end
        end
        S_HOLDOFF: begin
          w_hold_en = 1'b1;
          w_set_ovr = w_edge;
          if (w_hold_last) w_state_nxt = S_ARMED;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_done         <= 1'b0;
      r_timeout_flag <= 1'b0;
      r_overrun      <= 1'b0;
      r_fire_count   <= '0;
    end else if (w_arm) begin
      r_done         <= 1'b0;
      r_timeout_flag <= 1'b0;
      r_overrun      <= 1'b0;
      r_fire_count   <= '0;
    end else begin
      if (w_set_done) r_done         <= 1'b1;
      if (w_set_tout) r_timeout_flag <= 1'b1;
      if (w_set_ovr)  r_overrun      <= 1'b1;
      if (w_fire && (r_fire_count != 16'hFFFF)) r_fire_count <= r_fire_count + 16'd1;
    end
  end

  always_comb begin
    w_status0                   = 8'h00;
    w_status0[2:0]              = r_state;
    w_status0[STAT_DONE_BIT]    = r_done;
    w_status0[STAT_TIMEOUT_BIT] = r_timeout_flag;
    w_status0[STAT_OVERRUN_BIT] = r_overrun;
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_data_read <= 8'h00;
    end else if (reg_read) begin
      case (reg_cmd)
        ADDR_SKIP:    r_data_read <= sel_byte({16'h0000, r_skip}, reg_bytecount);
        ADDR_REPEAT:  r_data_read <= sel_byte({16'h0000, r_repeat}, reg_bytecount);
        ADDR_HOLDOFF: r_data_read <= sel_byte(r_holdoff, reg_bytecount);
        ADDR_TIMEOUT: r_data_read <= sel_byte(r_timeout, reg_bytecount);
        ADDR_STATUS:  r_data_read <= sel_byte({8'h00, r_fire_count, w_status0}, reg_bytecount);
        default:      r_data_read <= 8'h00;
      endcase
    end else begin
      r_data_read <= 8'h00;
    end
  end

  assign data_read   = r_data_read;
  assign trigger_out = w_fire;
  assign armed       = (r_state == S_ARMED) || (r_state == S_HOLDOFF);
  assign status_led  = w_status0[5:0];

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed scenarios plus randomized traffic for trigger_sequencer, checked
// cycle by cycle against a behavioural model of the sequencing rules.
module tb_trigger_sequencer;

  localparam int unsigned S_IDLE = 0, S_ARMED = 1, S_FIRE = 2, S_HOLDOFF = 3, S_DONE = 4, S_TOUT = 5;

  logic        clkin = 1'b0;
  logic        reset;
  logic [7:0]  reg_cmd;
  logic [15:0] reg_bytecount;
  logic [7:0]  reg_data_in;
  logic        reg_read, reg_write;
  logic [7:0]  data_read;
  logic        trigger_in;
  logic        trigger_out, armed;
  logic [5:0]  status_led;

  always #5 clkin = ~clkin;

  trigger_sequencer dut (
    .clkin(clkin), .reset(reset), .reg_cmd(reg_cmd), .reg_bytecount(reg_bytecount),
    .reg_data_in(reg_data_in), .reg_read(reg_read), .reg_write(reg_write),
    .data_read(data_read), .trigger_in(trigger_in), .trigger_out(trigger_out),
    .armed(armed), .status_led(status_led)
  );

  int checks = 0, failures = 0, cyc = 0;
  int fire_q[$], edge_q[$];
  bit prev_tin = 1'b0;

  // Reference model state
  int unsigned m_state, m_skip, m_rep, m_hold, m_tmo;
  int unsigned m_skipc, m_repc, m_holdc, m_tmoc, m_fc, m_rd;
  bit m_done, m_tout, m_ovr, m_trig_q;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned status0();
    return (32'(m_ovr) << 5) | (32'(m_tout) << 4) | (32'(m_done) << 3) | m_state;
  endfunction

  function automatic int unsigned rd_model(input int unsigned cmd, input int unsigned bc);
    int unsigned v = 0, n = 0;
    case (cmd)
      32'h31: begin v = m_skip; n = 2; end
      32'h32: begin v = m_rep;  n = 2; end
      32'h33: begin v = m_hold; n = 4; end
      32'h34: begin v = m_tmo;  n = 4; end
      32'h35: begin v = (m_fc << 8) | status0(); n = 3; end
      default: n = 0;
    endcase
    return (bc < n) ? ((v >> (8 * bc)) & 32'hFF) : 32'h0;
  endfunction

  function automatic int unsigned put_lane(input int unsigned v, input int unsigned n,
                                           input int unsigned bc, input int unsigned d);
    if (bc >= n) return v;
    return (v & ~(32'hFF << (8 * bc))) | (d << (8 * bc));
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_skip = 0; m_rep = 1; m_hold = 0; m_tmo = 0;
    m_skipc = 0; m_repc = 0; m_holdc = 0; m_tmoc = 0; m_fc = 0; m_rd = 0;
    m_done = 0; m_tout = 0; m_ovr = 0; m_trig_q = 0;
  endtask

  task automatic model_step();
    int unsigned cmd, bc, d, rd_next, t_after;
    bit edge_now, open, ctrl, abort, arm, tmo_on;
    cmd = 32'(reg_cmd); bc = 32'(reg_bytecount); d = 32'(reg_data_in);
    edge_now = trigger_in && !m_trig_q;
    open  = (m_state == S_IDLE) || (m_state == S_DONE) || (m_state == S_TOUT);
    ctrl  = reg_write && (cmd == 32'h30) && (bc == 0);
    abort = ctrl && ((d & 2) != 0);
    arm   = ctrl && ((d & 1) != 0) && !abort && open;
    rd_next = reg_read ? rd_model(cmd, bc) : 0;
    if (reg_write && open) begin
      case (cmd)
        32'h31: m_skip = put_lane(m_skip, 2, bc, d);
        32'h32: m_rep  = put_lane(m_rep,  2, bc, d);
        32'h33: m_hold = put_lane(m_hold, 4, bc, d);
        32'h34: m_tmo  = put_lane(m_tmo,  4, bc, d);
        default: ;
      endcase
    end
    if (abort) begin
      m_state = S_IDLE;
    end else begin
      case (m_state)
        S_IDLE, S_DONE, S_TOUT: if (arm) begin
          m_skipc = m_skip; m_repc = (m_rep == 0) ? 1 : m_rep; m_tmoc = m_tmo;
          m_done = 0; m_tout = 0; m_ovr = 0; m_fc = 0; m_state = S_ARMED;
        end
        S_ARMED: begin
          tmo_on  = (m_tmo != 0);
          t_after = (m_tmoc > 0) ? m_tmoc - 1 : 0;
          if (edge_now) begin
            if (m_skipc > 0) m_skipc--;
            else m_state = S_FIRE;
          end else if (tmo_on && t_after == 0) begin
            m_state = S_TOUT; m_tout = 1;
          end
          if (tmo_on) m_tmoc = t_after;
        end
        S_FIRE: begin
          if (m_fc < 65535) m_fc++;
          m_repc--;
          if (m_repc == 0) begin m_state = S_DONE; m_done = 1; end
          else if (m_hold != 0) begin m_state = S_HOLDOFF; m_holdc = m_hold; end
          else m_state = S_ARMED;
        end
        S_HOLDOFF: begin
          if (edge_now) m_ovr = 1;
          if (m_holdc > 0) m_holdc--;
          if (m_holdc == 0) m_state = S_ARMED;
        end
        default: m_state = S_IDLE;
      endcase
    end
    m_trig_q = trigger_in;
    m_rd = rd_next;
  endtask

  // Called at a falling edge with inputs already driven for this cycle.
  task automatic cycle();
    bit abort_now;
    #2;
    abort_now = reg_write && (reg_cmd == 8'h30) && (reg_bytecount == 16'h0) && reg_data_in[1];
    check_val("trigger_out", 32'(trigger_out), 32'(m_state == S_FIRE && !abort_now));
    check_val("armed", 32'(armed), 32'(m_state == S_ARMED || m_state == S_HOLDOFF));
    check_val("status_led", 32'(status_led), status0());
    check_val("data_read", 32'(data_read), m_rd);
    if (trigger_out === 1'b1) fire_q.push_back(cyc);
    if (trigger_in && !prev_tin) edge_q.push_back(cyc);
    prev_tin = trigger_in;
    model_step();
    cyc++;
    @(posedge clkin);
    @(negedge clkin);
  endtask

  task automatic idle_in();
    reg_write = 0; reg_read = 0; reg_cmd = 8'h00; reg_bytecount = 16'h0; reg_data_in = 8'h00;
  endtask

  task automatic idle(input int n);
    idle_in();
    repeat (n) cycle();
  endtask

  task automatic wr(input logic [7:0] cmd, input int unsigned bc, input int unsigned d);
    reg_write = 1; reg_cmd = cmd; reg_bytecount = 16'(bc); reg_data_in = 8'(d);
    cycle();
    idle_in();
  endtask

  task automatic wr_reg(input logic [7:0] cmd, input int unsigned v, input int unsigned n);
    for (int unsigned b = 0; b < n; b++) wr(cmd, b, (v >> (8 * b)) & 32'hFF);
  endtask

  task automatic rd_expect(input string tag, input logic [7:0] cmd, input int unsigned bc,
                           input int unsigned exp);
    reg_read = 1; reg_cmd = cmd; reg_bytecount = 16'(bc);
    cycle();
    idle_in();
    check_val(tag, 32'(data_read), exp);
  endtask

  task automatic pulse(input int hi, input int lo);
    trigger_in = 1; repeat (hi) cycle();
    trigger_in = 0; repeat (lo) cycle();
  endtask

  task automatic async_reset(input string tag);
    #3 reset = 1;
    #1;
    check_val({tag, "_trig"},   32'(trigger_out), 32'h0);
    check_val({tag, "_armed"},  32'(armed),       32'h0);
    check_val({tag, "_status"}, 32'(status_led),  32'h0);
    check_val({tag, "_rdata"},  32'(data_read),   32'h0);
    model_reset();
    @(posedge clkin);
    @(negedge clkin);
    reset = 0;
  endtask

  initial begin
    int mn;
    int unsigned r;
    reset = 1; trigger_in = 0; idle_in(); model_reset();
    @(negedge clkin); @(negedge clkin);
    check_val("rst_trig",   32'(trigger_out), 32'h0);
    check_val("rst_armed",  32'(armed),       32'h0);
    check_val("rst_status", 32'(status_led),  32'h0);
    check_val("rst_rdata",  32'(data_read),   32'h0);
    reset = 0;
    idle(2);

    // Default config: one edge, one fire a cycle later, then DONE.
    wr(8'h30, 0, 1);
    idle(3);
    fire_q.delete(); edge_q.delete();
    pulse(1, 3);
    idle(2);
    check_val("s1_pulses", 32'(fire_q.size()), 32'd1);
    if (fire_q.size() == 1 && edge_q.size() == 1)
      check_val("s1_latency", 32'(fire_q[0] - edge_q[0]), 32'd1);
    rd_expect("s1_status0", 8'h35, 0, 32'h0C);
    rd_expect("s1_fc_lo",   8'h35, 1, 32'h01);
    rd_expect("s1_fc_hi",   8'h35, 2, 32'h00);

    // Skip three edges, fire on the fourth only.
    wr_reg(8'h31, 3, 2);
    wr(8'h30, 0, 1);
    fire_q.delete(); edge_q.delete();
    repeat (5) pulse(1, 2);
    idle(2);
    check_val("s2_pulses", 32'(fire_q.size()), 32'd1);
    if (fire_q.size() == 1 && edge_q.size() == 5)
      check_val("s2_fire_edge4", 32'(fire_q[0]), 32'(edge_q[3] + 1));
    rd_expect("s2_status0", 8'h35, 0, 32'h0C);

    // Three fires separated by holdoff, edges during holdoff flag overrun.
    wr_reg(8'h31, 0, 2);
    wr_reg(8'h32, 3, 2);
    wr_reg(8'h33, 10, 4);
    wr(8'h30, 0, 1);
    fire_q.delete(); edge_q.delete();
    repeat (20) pulse(1, 3);
    check_val("s3_pulses", 32'(fire_q.size()), 32'd3);
    mn = 1000;
    for (int i = 1; i < fire_q.size(); i++)
      if (fire_q[i] - fire_q[i-1] < mn) mn = fire_q[i] - fire_q[i-1];
    check_val("s3_spacing_ge11", 32'(mn >= 11), 32'd1);
    rd_expect("s3_status0", 8'h35, 0, 32'h2C);
    rd_expect("s3_fc_lo",   8'h35, 1, 32'h03);

    // Arm timeout with no edges: 50 armed cycles, then TOUT.
    wr_reg(8'h32, 1, 2);
    wr_reg(8'h33, 0, 4);
    wr_reg(8'h34, 50, 4);
    wr(8'h30, 0, 1);
    fire_q.delete();
    idle(49);
    check_val("s4_still_armed", 32'(status_led), 32'h01);
    idle(1);
    check_val("s4_tout", 32'(status_led), 32'h15);
    idle(5);
    check_val("s4_no_fire", 32'(fire_q.size()), 32'd0);
    rd_expect("s4_status0", 8'h35, 0, 32'h15);

    // Config write while armed is dropped; ABORT beats ARM.
    wr_reg(8'h34, 0, 4);
    wr_reg(8'h31, 2, 2);
    wr(8'h30, 0, 1);
    idle(2);
    wr(8'h31, 0, 7);
    wr(8'h30, 0, 3);
    check_val("s5_idle_status", 32'(status_led), 32'h00);
    check_val("s5_not_armed",   32'(armed),      32'h0);
    idle(3);
    check_val("s5_stays_idle",  32'(status_led), 32'h00);
    rd_expect("s5_skip_lo", 8'h31, 0, 32'h02);
    rd_expect("s5_skip_hi", 8'h31, 1, 32'h00);

    // Reset in the middle of a holdoff window.
    wr_reg(8'h31, 0, 2);
    wr_reg(8'h32, 2, 2);
    wr_reg(8'h33, 20, 4);
    wr(8'h30, 0, 1);
    pulse(1, 3);
    check_val("s6_armed_in_holdoff", 32'(armed), 32'h1);
    check_val("s6_state_holdoff", 32'(status_led[2:0]), 32'h3);
    reg_read = 1; reg_cmd = 8'h35; cycle(); idle_in();
    async_reset("s6_reset");
    rd_expect("s6_skip0", 8'h31, 0, 32'h00);
    rd_expect("s6_skip1", 8'h31, 1, 32'h00);
    rd_expect("s6_rep0",  8'h32, 0, 32'h01);
    rd_expect("s6_rep1",  8'h32, 1, 32'h00);
    for (int unsigned b = 0; b < 4; b++) begin
      rd_expect("s6_hold", 8'h33, b, 32'h00);
      rd_expect("s6_tmo",  8'h34, b, 32'h00);
    end
    rd_expect("s6_status", 8'h35, 0, 32'h00);
    idle(1);
    check_val("s6_rdata_unaddressed", 32'(data_read), 32'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) async_reset("rnd_reset");
      idle_in();
      if ($urandom_range(0, 3) == 0) trigger_in = ~trigger_in;
      r = $urandom_range(0, 99);
      if (r < 5) begin
        reg_write = 1;
        reg_cmd = 8'(32'h31 + $urandom_range(0, 3));
        reg_bytecount = 16'($urandom_range(0, 4));
        if (reg_bytecount == 16'd0)      reg_data_in = 8'($urandom_range(0, 12));
        else if (reg_bytecount == 16'd1) reg_data_in = 8'(($urandom_range(0, 7) == 0) ? 1 : 0);
        else                             reg_data_in = 8'h00;
      end else if (r < 9) begin
        reg_write = 1;
        reg_cmd = 8'h30;
        reg_bytecount = 16'($urandom_range(0, 1) & $urandom_range(0, 1));
        reg_data_in = 8'(($urandom_range(0, 3) == 0) ? $urandom_range(2, 3) : 1);
      end else if (r < 20) begin
        reg_read = 1;
        reg_cmd = 8'(32'h2F + $urandom_range(0, 7));
        reg_bytecount = 16'($urandom_range(0, 4));
      end
      cycle();
    end
    idle_in();
    trigger_in = 0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
